crono_reader: RTL and testbench



---
 rtl/crono_reader.sv | 234 +++++++++++++++++++++++
 tb/tb_crono_reader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crono_reader.sv
// crono_reader
//   Reads the chronometer registers (hours, minutes, seconds) back from the
//   external RTC over the shared multiplexed AD bus. A rising edge on start
//   runs three read cycles (hours, minutes, seconds). Each cycle is an address
//   phase (ad/cs/wr strobes, address driven on ad_out) followed by a bus
//   turnaround and a data phase (cs/rd strobes, data sampled from ad_in).
//   All three values are published together with a one-cycle done pulse.
//   The bus is released when idle so the chronometer writer can use it.
//
// Ports
//   clock    system clock, rising edge
//   reset    synchronous, active-high reset
//   start    level request; a 0->1 transition starts a transaction
//   ad_in    AD bus value from the pad
//   ad_out   AD bus drive value (register address during the address phase)
//   ad_oe    AD bus output enable, 1 = drive ad_out
//   ctrl_oe  pad enable for ad/cs/wr/rd, 0 = released
//   ad       address strobe, low during the address phase
//   cs       chip select, active low
//   wr       write strobe, active low
//   rd       read strobe, active low
//   horac    last hours value read
//   minc     last minutes value read
//   segc     last seconds value read
//   busy     transaction in progress
//   done     one-cycle pulse when horac/minc/segc are updated
module crono_reader #(
  parameter logic [7:0]  ADDR_H = 8'h43,
  parameter logic [7:0]  ADDR_M = 8'h42,
  parameter logic [7:0]  ADDR_S = 8'h41,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned TURN   = 3,
  parameter int unsigned RD_W   = 4,
  parameter int unsigned GAP    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       ctrl_oe,
  output logic       ad,
  output logic       cs,
  output logic       wr,
  output logic       rd,
  output logic [7:0] horac,
  output logic [7:0] minc,
  output logic [7:0] segc,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_AD_LO,
    S_CS_LO,
    S_WR_LO,
    S_A_HOLD,
    S_WR_HI,
    S_CS_HI,
    S_AD_HI,
    S_TURN,
    S_RCS,
    S_RD_LO,
    S_RD_HI,
    S_CS_END,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       slot;
  logic [1:0]       slot_nxt;
  logic             start_q;
  logic             armed;
  logic             trig;
  logic [7:0]       sh_h;
  logic [7:0]       sh_m;
  logic [7:0]       sh_s;

  // armed blocks a trigger while start has been high continuously since
  // reset; it is loaded from start at the reset edge so that a start level
  // present during reset never counts as a 0->1 transition.
  assign trig = start & ~start_q & armed;

  function automatic logic [7:0] slot_addr(input logic [1:0] s);
    case (s)
      2'd0:    slot_addr = ADDR_H;
      2'd1:    slot_addr = ADDR_M;
      2'd2:    slot_addr = ADDR_S;
      default: slot_addr = '0;
    endcase
  endfunction

  // Multi-cycle states load cnt with (length-1) on entry and leave at zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    slot_nxt  = slot;
    case (state)
      S_IDLE: begin
        if (trig) begin
          state_nxt = S_SETUP;
          slot_nxt  = '0;
        end
      end
      S_SETUP: state_nxt = S_AD_LO;
      S_AD_LO: state_nxt = S_CS_LO;
      S_CS_LO: state_nxt = S_WR_LO;
      S_WR_LO: begin
        state_nxt = S_A_HOLD;
        cnt_nxt   = CNT_W'(ADDR_W - 1);
      end
      S_A_HOLD: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else           state_nxt = S_WR_HI;
      end
      S_WR_HI: state_nxt = S_CS_HI;
      S_CS_HI: state_nxt = S_AD_HI;
      S_AD_HI: begin
        state_nxt = S_TURN;
        cnt_nxt   = CNT_W'(TURN - 1);
      end
      S_TURN: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else           state_nxt = S_RCS;
      end
      S_RCS: begin
        state_nxt = S_RD_LO;
        cnt_nxt   = CNT_W'(RD_W - 1);
      end
      S_RD_LO: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else           state_nxt = S_RD_HI;
      end
      S_RD_HI: state_nxt = S_CS_END;
      S_CS_END: begin
        state_nxt = S_GAP;
        cnt_nxt   = CNT_W'(GAP - 1);
      end
      S_GAP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (slot == 2'd2) begin
          state_nxt = S_DONE;
        end else begin
          slot_nxt  = slot + 2'd1;
          state_nxt = S_SETUP;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Slot 3 does not exist; fall back to idle rather than read a bogus address.
    if (state != S_IDLE && slot == 2'd3) begin
      state_nxt = S_IDLE;
      slot_nxt  = '0;
    end
  end

  // Outputs are decoded from the next state so they are registered yet
  // aligned with the state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      slot    <= '0;
      start_q <= 1'b0;
      armed   <= ~start;
      ad_out  <= '0;
      ad_oe   <= 1'b0;
      ctrl_oe <= 1'b0;
      ad      <= 1'b1;
      cs      <= 1'b1;
      wr      <= 1'b1;
      rd      <= 1'b1;
      horac   <= '0;
      minc    <= '0;
      segc    <= '0;
      sh_h    <= '0;
      sh_m    <= '0;
      sh_s    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      start_q <= start;
      armed   <= armed | ~start;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      slot    <= slot_nxt;

      ctrl_oe <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      busy    <= (state_nxt != S_IDLE);
      done    <= (state_nxt == S_DONE);
      ad      <= !(state_nxt inside {S_AD_LO, S_CS_LO, S_WR_LO, S_A_HOLD,
                                     S_WR_HI, S_CS_HI});
      cs      <= !(state_nxt inside {S_CS_LO, S_WR_LO, S_A_HOLD, S_WR_HI,
                                     S_RCS, S_RD_LO, S_RD_HI});
      wr      <= !(state_nxt inside {S_WR_LO, S_A_HOLD});
      rd      <= (state_nxt != S_RD_LO);

      if (state_nxt inside {S_WR_LO, S_A_HOLD, S_WR_HI, S_CS_HI}) begin
        ad_oe  <= 1'b1;
        ad_out <= slot_addr(slot_nxt);
      end else begin
        ad_oe  <= 1'b0;
        ad_out <= '0;
      end

      if (state == S_RD_LO && state_nxt == S_RD_HI) begin
        case (slot)
          2'd0:    sh_h <= ad_in;
          2'd1:    sh_m <= ad_in;
          2'd2:    sh_s <= ad_in;
          default: ;
        endcase
      end

      if (state_nxt == S_DONE) begin
        horac <= sh_h;
        minc  <= sh_m;
        segc  <= sh_s;
      end
    end
  end

endmodule

// File: tb/tb_crono_reader.sv
module tb_crono_reader;

  localparam int unsigned AW0 = 4, T0 = 3, RW0 = 4, G0 = 8;
  localparam int unsigned AW1 = 1, T1 = 1, RW1 = 1, G1 = 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, start, reset_f, start_f;
  logic [7:0] ad_in, ad_in_f;
  logic [7:0] ad_out, ad_out_f, horac, horac_f, minc, minc_f, segc, segc_f;
  logic       ad_oe, ctrl_oe, ad, cs, wr, rd, busy, done;
  logic       ad_oe_f, ctrl_oe_f, ad_f, cs_f, wr_f, rd_f, busy_f, done_f;

  crono_reader dut (
    .clock(clock), .reset(reset), .start(start), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .ctrl_oe(ctrl_oe), .ad(ad), .cs(cs),
    .wr(wr), .rd(rd), .horac(horac), .minc(minc), .segc(segc),
    .busy(busy), .done(done)
  );

  crono_reader #(.ADDR_W(AW1), .TURN(T1), .RD_W(RW1), .GAP(G1)) dut_f (
    .clock(clock), .reset(reset_f), .start(start_f), .ad_in(ad_in_f),
    .ad_out(ad_out_f), .ad_oe(ad_oe_f), .ctrl_oe(ctrl_oe_f), .ad(ad_f),
    .cs(cs_f), .wr(wr_f), .rd(rd_f), .horac(horac_f), .minc(minc_f),
    .segc(segc_f), .busy(busy_f), .done(done_f)
  );

  int total = 0;
  int bad   = 0;

  // RTC model and bus observer state, one entry per DUT (0 default, 1 fast)
  logic [7:0] mem [2][256];
  logic [7:0] rtc_addr [2];
  logic [7:0] wr_addr [2];
  int         ncnt [2];
  logic       wr_p [2], rd_p [2], ad_p [2], cs_p [2];
  int         ad_fall [2], cs_fall [2];
  logic [7:0] addr_log [2][8];
  int         addr_n [2];
  int         wr_len [2], rd_len [2];
  int         wr_runs [2][8], rd_runs [2][8];
  int         wr_rn [2], rd_rn [2];
  int         viol [2], order_bad [2];
  int         done_n [2], done_stamp [2];
  int         busy_first [2], busy_last [2];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_logs(input int d);
    addr_n[d] = 0; wr_len[d] = 0; rd_len[d] = 0; wr_rn[d] = 0; rd_rn[d] = 0;
    viol[d] = 0; order_bad[d] = 0; done_n[d] = 0; done_stamp[d] = 0;
    busy_first[d] = -1; busy_last[d] = -1; ad_fall[d] = 0; cs_fall[d] = 0;
  endtask

  task automatic mon(input int d, input logic wr_v, rd_v, ad_v, cs_v, oe_v,
                     input logic [7:0] out_v, input logic done_v, busy_v,
                     output logic [7:0] din);
    ncnt[d]++;
    if (ad_p[d] && !ad_v) ad_fall[d] = ncnt[d];
    if (cs_p[d] && !cs_v) cs_fall[d] = ncnt[d];
    if (!wr_v && oe_v) rtc_addr[d] = out_v;
    if (wr_p[d] && !wr_v) begin
      wr_addr[d] = out_v;
      if (addr_n[d] < 8) addr_log[d][addr_n[d]] = out_v;
      addr_n[d]++;
      if (ad_v || cs_v || ad_fall[d] >= cs_fall[d]) order_bad[d]++;
    end
    if (!wr_v) begin
      wr_len[d]++;
      if (!oe_v || out_v != wr_addr[d]) order_bad[d]++;
    end
    if (!wr_p[d] && wr_v) begin
      if (wr_rn[d] < 8) wr_runs[d][wr_rn[d]] = wr_len[d];
      wr_rn[d]++; wr_len[d] = 0;
    end
    if (!rd_v) rd_len[d]++;
    if (!rd_p[d] && rd_v) begin
      if (rd_rn[d] < 8) rd_runs[d][rd_rn[d]] = rd_len[d];
      rd_rn[d]++; rd_len[d] = 0;
    end
    if (!rd_v && !wr_v) viol[d]++;
    if (oe_v && !rd_v) viol[d]++;
    if (done_v) begin done_n[d]++; done_stamp[d] = ncnt[d]; end
    if (busy_v) begin
      if (busy_first[d] < 0) busy_first[d] = ncnt[d];
      busy_last[d] = ncnt[d];
    end
    // the RTC only drives valid data while rd is low; anything else is junk
    din = !rd_v ? mem[d][rtc_addr[d]] : 8'($urandom);
    wr_p[d] = wr_v; rd_p[d] = rd_v; ad_p[d] = ad_v; cs_p[d] = cs_v;
  endtask

  always @(negedge clock) begin
    mon(0, wr, rd, ad, cs, ad_oe, ad_out, done, busy, ad_in);
    mon(1, wr_f, rd_f, ad_f, cs_f, ad_oe_f, ad_out_f, done_f, busy_f, ad_in_f);
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 0) start = v; else start_f = v;
  endtask

  function automatic int slot_len(input int d);
    if (d == 0) return 10 + AW0 + T0 + RW0 + G0;
    return 10 + AW1 + T1 + RW1 + G1;
  endfunction

  function automatic int addr_hold(input int d);
    return (d == 0) ? AW0 + 1 : AW1 + 1;
  endfunction

  function automatic int rd_hold(input int d);
    return (d == 0) ? RW0 : RW1;
  endfunction

  task automatic run_txn(input int d, input logic [7:0] h, m, s,
                         input logic [7:0] eh, em, es);
    int base;
    int lim;
    int exp_done;
    mem[d][8'h43] = h; mem[d][8'h42] = m; mem[d][8'h41] = s;
    clear_logs(d);
    set_start(d, 1'b0);
    tick();
    set_start(d, 1'b1);
    base = ncnt[d];
    lim = 0;
    while (done_n[d] == 0 && lim < 400) begin tick(); lim++; end
    repeat (3) tick();
    set_start(d, 1'b0);
    tick();
    exp_done = 1 + 3 * slot_len(d);
    check("done_count", done_n[d], 1);
    check("done_cycle", done_stamp[d] - base - 1, exp_done);
    check("busy_first", busy_first[d] - base - 1, 1);
    check("busy_last", busy_last[d] - base - 1, exp_done);
    check("horac", (d == 0) ? horac : horac_f, eh);
    check("minc", (d == 0) ? minc : minc_f, em);
    check("segc", (d == 0) ? segc : segc_f, es);
    check("addr_count", addr_n[d], 3);
    check("addr_h", addr_log[d][0], 8'h43);
    check("addr_m", addr_log[d][1], 8'h42);
    check("addr_s", addr_log[d][2], 8'h41);
    check("rd_pulses", rd_rn[d], 3);
    check("wr_pulses", wr_rn[d], 3);
    for (int i = 0; i < 3; i++) begin
      check("rd_low_len", rd_runs[d][i], rd_hold(d));
      check("wr_low_len", wr_runs[d][i], addr_hold(d));
    end
    check("rd_wr_oe_violations", viol[d], 0);
    check("strobe_order", order_bad[d], 0);
  endtask

  typedef struct {
    logic [7:0] h, m, s;
    logic [7:0] eh, em, es;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int base;
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 256; a++) mem[d][a] = '0;
      ncnt[d] = 0; rtc_addr[d] = '0; wr_addr[d] = '0;
      wr_p[d] = 1'b1; rd_p[d] = 1'b1; ad_p[d] = 1'b1; cs_p[d] = 1'b1;
      clear_logs(d);
    end
    reset = 1'b1; reset_f = 1'b1; start = 1'b0; start_f = 1'b0;
    ad_in = '0; ad_in_f = '0;

    tbl[0] = '{8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56};
    tbl[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2] = '{8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff};
    tbl[3] = '{8'h23, 8'h59, 8'h59, 8'h23, 8'h59, 8'h59};
    for (int i = 4; i < 8; i++) begin
      tbl[i].h = 8'($urandom); tbl[i].m = 8'($urandom); tbl[i].s = 8'($urandom);
      tbl[i].eh = tbl[i].h; tbl[i].em = tbl[i].m; tbl[i].es = tbl[i].s;
    end

    repeat (3) tick();
    reset = 1'b0; reset_f = 1'b0;
    clear_logs(0);
    repeat (10) tick();
    check("idle_ctrl_oe", ctrl_oe, 0);
    check("idle_ad_oe", ad_oe, 0);
    check("idle_ad_out", ad_out, 0);
    check("idle_strobes", {ad, cs, wr, rd}, 4'hf);
    check("idle_time", {horac, minc, segc}, 0);
    check("idle_busy", busy, 0);
    check("idle_done_seen", done_n[0], 0);

    for (int i = 0; i < 8; i++) begin
      run_txn(0, tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].eh, tbl[i].em, tbl[i].es);
      repeat ($urandom_range(0, 5)) tick();
    end

    // start held high; re-edges at cycle 40 (busy) and 88 (DONE) are ignored
    mem[0][8'h43] = 8'h12; mem[0][8'h42] = 8'h34; mem[0][8'h41] = 8'h56;
    clear_logs(0);
    start = 1'b0; tick(); start = 1'b1; base = ncnt[0];
    for (int c = 1; c <= 150; c++) begin
      tick();
      if (c == 39 || c == 87) start = 1'b0;
      if (c == 40 || c == 88) start = 1'b1;
    end
    check("hold_done_count", done_n[0], 1);
    check("hold_done_cycle", done_stamp[0] - base - 1, 88);
    check("hold_busy_last", busy_last[0] - base - 1, 88);
    check("hold_horac", horac, 8'h12);

    // an edge in the first idle cycle after DONE is accepted
    mem[0][8'h43] = 8'h01; mem[0][8'h42] = 8'h02; mem[0][8'h41] = 8'h03;
    clear_logs(0);
    start = 1'b0; tick(); start = 1'b1; base = ncnt[0];
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (c == 88) start = 1'b0;
      if (c == 89) start = 1'b1;
    end
    start = 1'b0; tick();
    check("post_done_count", done_n[0], 2);
    check("post_done_cycle", done_stamp[0] - base - 1, 177);
    check("post_done_segc", segc, 8'h03);

    // reset in slot 1 after a completed 12/34/56 read
    run_txn(0, 8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56);
    mem[0][8'h43] = 8'h77; mem[0][8'h42] = 8'h88; mem[0][8'h41] = 8'h99;
    clear_logs(0);
    start = 1'b0; tick(); start = 1'b1; base = ncnt[0];
    repeat (50) tick();
    reset = 1'b1;
    tick();
    check("rst_ctrl_oe", ctrl_oe, 0);
    check("rst_ad_oe", ad_oe, 0);
    check("rst_ad_out", ad_out, 0);
    check("rst_strobes", {ad, cs, wr, rd}, 4'hf);
    check("rst_horac", horac, 0);
    check("rst_minc", minc, 0);
    check("rst_segc", segc, 0);
    check("rst_busy", busy, 0);
    start = 1'b0; tick();
    start = 1'b1; tick();      // rising edge seen only while reset is high
    reset = 1'b0;
    repeat (20) tick();
    check("rst_no_done", done_n[0], 0);
    check("rst_busy_last", busy_last[0] - base - 1, 50);
    check("rst_no_retrigger", busy, 0);
    start = 1'b0; tick();
    run_txn(0, 8'h77, 8'h88, 8'h99, 8'h77, 8'h88, 8'h99);

    // minimum timing parameters
    for (int i = 0; i < 3; i++) begin
      logic [7:0] h, m, s;
      h = 8'($urandom); m = 8'($urandom); s = 8'($urandom);
      run_txn(1, h, m, s, h, m, s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
